// File: rtl/acc_dump_scaler.sv
// Multi-channel integrate-and-dump accumulator with shifted readout over valid/ready streams.
// Define ACC_DUMP_SCALER_SAT_EN to saturate accumulation and scaling instead of wrapping.
module acc_dump_scaler #(
  parameter int LEN   = 8,
  parameter int CH    = 4,
  parameter int DUMP  = 16,
  parameter int SHIFT = 1,
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [LEN-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [LEN-1:0] out_data,
  output logic [CHW-1:0] out_ch
);

  localparam int RW = (DUMP > 1) ? $clog2(DUMP) : 1;

  // Handshake: a beat moves on a rising edge where valid && ready && !clear.
  typedef enum logic {ST_ACC, ST_DUMP} state_t;

  state_t         state, state_next;
  logic [LEN-1:0] acc [CH];
  logic [CHW-1:0] ptr, dump_idx;
  logic [RW-1:0]  round_cnt;
  logic           accept, fire, last_ptr, last_round, last_dump;
  logic [LEN:0]   sum;
  logic [LEN-1:0] acc_next, cur, scaled;

  assign last_ptr   = (ptr == CHW'(CH - 1));
  assign last_round = (round_cnt == RW'(DUMP - 1));
  assign last_dump  = (dump_idx == CHW'(CH - 1));
  assign sum        = {1'b0, acc[ptr]} + {1'b0, in_data};
  assign cur        = acc[dump_idx];

`ifdef ACC_DUMP_SCALER_SAT_EN
  assign acc_next = sum[LEN] ? '1 : sum[LEN-1:0];
  // Any bit that would be shifted out forces full scale.
  assign scaled   = ((cur >> (LEN - SHIFT)) != '0) ? '1 : (cur << SHIFT);
`else
  assign acc_next = sum[LEN-1:0];
  assign scaled   = cur << SHIFT;
`endif

  always_comb begin
    state_next = state;
    in_ready   = (state == ST_ACC);
    out_valid  = (state == ST_DUMP);
    out_data   = '0;
    out_ch     = '0;
    accept     = in_valid && in_ready && !clear;
    fire       = out_valid && out_ready && !clear;
    if (out_valid) begin
      out_data = scaled;
      out_ch   = dump_idx;
    end
    case (state)
      ST_ACC:  if (accept && last_ptr && last_round) state_next = ST_DUMP;
      ST_DUMP: if (fire && last_dump) state_next = ST_ACC;
      default: state_next = ST_ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACC;
      ptr       <= '0;
      dump_idx  <= '0;
      round_cnt <= '0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else if (clear) begin
      state     <= ST_ACC;
      ptr       <= '0;
      dump_idx  <= '0;
      round_cnt <= '0;
      for (int i = 0; i < CH; i++) acc[i] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc[ptr] <= acc_next;
        if (last_ptr) begin
          ptr <= '0;
          if (last_round) begin
            round_cnt <= '0;
            dump_idx  <= '0;
          end else begin
            round_cnt <= round_cnt + 1'b1;
          end
        end else begin
          ptr <= ptr + 1'b1;
        end
      end
      if (fire) begin
        acc[dump_idx] <= '0;
        dump_idx      <= last_dump ? '0 : dump_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_dump_scaler.sv
// Scoreboard bench for acc_dump_scaler at default parameters (LEN=8, CH=4, DUMP=16, SHIFT=1).
module tb_acc_dump_scaler;

  localparam int LEN = 8;
  localparam int CH  = 4;
  localparam int DMP = 16;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst_n, clear, in_valid, in_ready, out_valid, out_ready;
  logic [LEN-1:0] in_data, out_data;
  logic [CHW-1:0] out_ch;

  logic [CHW+LEN-1:0] exp_q[$];
  logic [LEN-1:0]     m_acc [CH];
  int                 m_ptr, m_round;
  int                 checks = 0;
  int                 errors = 0;

  acc_dump_scaler dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch)
  );

  always #5 clk = ~clk;

  function automatic logic [LEN-1:0] m_add(input logic [LEN-1:0] a, input logic [LEN-1:0] d);
    logic [LEN:0] s;
    s = {1'b0, a} + {1'b0, d};
`ifdef ACC_DUMP_SCALER_SAT_EN
    return s[LEN] ? 8'hff : s[LEN-1:0];
`else
    return s[LEN-1:0];
`endif
  endfunction

  function automatic logic [LEN-1:0] m_scale(input logic [LEN-1:0] a);
`ifdef ACC_DUMP_SCALER_SAT_EN
    return a[LEN-1] ? 8'hff : {a[LEN-2:0], 1'b0};
`else
    return {a[LEN-2:0], 1'b0};
`endif
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) m_acc[c] = '0;
    m_ptr   = 0;
    m_round = 0;
  endtask

  // One clock: inspect the beat that the coming edge transfers, then return 1ns after the edge.
  task automatic cycle();
    logic [CHW+LEN-1:0] e;
    @(negedge clk);
    if (rst_n && !clear && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat got ch=%0d data=%0d expected no beat", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_ch, out_data} !== e) begin
          errors++;
          $display("FAIL dump_beat got ch=%0d data=%0d expected ch=%0d data=%0d",
                   out_ch, out_data, e[CHW+LEN-1:LEN], e[LEN-1:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [LEN-1:0] d);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 200) begin
      cycle();
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b expected 1", in_ready);
    end else begin
      cycle();
      m_acc[m_ptr] = m_add(m_acc[m_ptr], d);
      if (m_ptr == CH - 1) begin
        m_ptr = 0;
        if (m_round == DMP - 1) begin
          m_round = 0;
          for (int c = 0; c < CH; c++) begin
            exp_q.push_back({CHW'(c), m_scale(m_acc[c])});
            m_acc[c] = '0;
          end
        end else begin
          m_round++;
        end
      end else begin
        m_ptr++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_bp);
    int guard = 0;
    while (!in_ready && guard < 300) begin
      out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle();
      guard++;
    end
    out_ready = 1'b1;
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL drain_timeout in_ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({in_ready, out_valid, out_data, out_ch} !== {1'b1, 1'b0, 8'd0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b data=%0d ch=%0d expected 1 0 0 0",
               in_ready, out_valid, out_data, out_ch);
    end
    cycle(); cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL post_reset got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_constant();
    int n;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < CH * DMP; i++) send(8'd1);
      checks++;
      if ({out_valid, out_ch, out_data, in_ready} !== {1'b1, 2'd0, 8'd32, 1'b0}) begin
        errors++;
        $display("FAIL const_first_beat period=%0d got valid=%b ch=%0d data=%0d in_ready=%b expected 1 0 32 0",
                 p, out_valid, out_ch, out_data, in_ready);
      end
      n = 0;
      while (out_valid && n < 10) begin
        cycle();
        n++;
      end
      checks++;
      if (n != CH || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dump_length got %0d cycles in_ready=%b expected %0d cycles in_ready=1", n, in_ready, CH);
      end
    end
  endtask

  task automatic test_wrap();
    logic [LEN-1:0] want;
`ifdef ACC_DUMP_SCALER_SAT_EN
    want = 8'd255;
`else
    want = 8'd88;
`endif
    for (int r = 0; r < DMP; r++)
      for (int c = 0; c < CH; c++)
        send((c == 0 && r == 0) ? 8'd200 : (c == 0 && r == 1) ? 8'd100 :
             (c == 1 && r == 0) ? 8'd128 : 8'd0);
    checks++;
    if (out_data !== want) begin
      errors++;
      $display("FAIL wrap_ch0 got %0d expected %0d", out_data, want);
    end
    wait_idle(1'b0);
  endtask

  task automatic test_random();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < CH * DMP; i++) send(LEN'($urandom_range(0, 255)));
      wait_idle(1'b1);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < CH * DMP - 1; i++) send(LEN'($urandom_range(0, 40)));
    out_ready = 1'b0;
    send(LEN'($urandom_range(0, 40)));
    in_valid = 1'b1;
    in_data  = 8'd9;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (!out_valid || in_ready || {out_ch, out_data} !== exp_q[0]) begin
        errors++;
        $display("FAIL backpressure_hold cycle=%0d got valid=%b in_ready=%b ch=%0d data=%0d expected 1 0 ch=%0d data=%0d",
                 k, out_valid, in_ready, out_ch, out_data, exp_q[0][CHW+LEN-1:LEN], exp_q[0][LEN-1:0]);
      end
    end
    in_valid = 1'b0;
    wait_idle(1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) send(LEN'($urandom_range(1, 255)));
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd9;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    model_reset();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL clear_acc got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < CH * DMP; i++) send(LEN'($urandom_range(0, 255)));
    wait_idle(1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < CH * DMP; i++) send(LEN'($urandom_range(0, 255)));
    clear = 1'b1; out_ready = 1'b1;
    cycle();
    clear = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_data} !== {1'b1, 1'b0, 8'd0} || exp_q.size() != CH) begin
      errors++;
      $display("FAIL clear_dump got in_ready=%b out_valid=%b data=%0d pending=%0d expected 1 0 0 %0d",
               in_ready, out_valid, out_data, exp_q.size(), CH);
    end
    exp_q.delete();
    model_reset();
    for (int i = 0; i < CH * DMP; i++) send(LEN'($urandom_range(0, 255)));
    wait_idle(1'b0);
  endtask

  task automatic test_reset_mid_dump();
    for (int i = 0; i < CH * DMP; i++) send(LEN'($urandom_range(0, 255)));
    cycle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 8'd0} || exp_q.size() != CH - 1) begin
      errors++;
      $display("FAIL reset_mid_dump got out_valid=%b in_ready=%b data=%0d pending=%0d expected 0 1 0 %0d",
               out_valid, in_ready, out_data, exp_q.size(), CH - 1);
    end
    exp_q.delete();
    model_reset();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < CH * DMP; i++) send(8'd2);
    wait_idle(1'b0);
  endtask

  initial begin
    test_reset();
    test_constant();
    test_wrap();
    test_random();
    test_backpressure();
    test_clear();
    test_reset_mid_dump();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_dump_scaler.md
Name: acc_dump_scaler

Overview:
- Parametrised, multi-channel integrate-and-dump accumulator with a scaled readout; successor to the single-channel free-running accumulator/doubler.
- Input samples arrive through a valid/ready stream and are assigned round-robin to CH channel accumulators.
- After DUMP complete rounds, each accumulator is left-shifted by SHIFT and streamed out in channel order over a valid/ready stream, then cleared.
- Sits between a sample source and downstream decimated processing.

Parameters:
- LEN, 8: data width of the input, the accumulators and the output.
- CH, 4: number of channels, ≥1. CHW = max(1, clog2(CH)).
- DUMP, 16: rounds per integration period, ≥1. One round is CH accepted samples.
- SHIFT, 1: output left-shift, 0 ≤ SHIFT < LEN. Result is truncated to LEN bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  LEN  unsigned sample.
- out_valid  out  1  output result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LEN  scaled accumulator value.
- out_ch  out  CHW  channel index of out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all accumulators = 0; ptr, round_cnt and dump_idx = 0; state = ACC.
  - out_valid = 0, out_data = 0, out_ch = 0, in_ready = 1.
- State ACC:
  - in_ready = 1, out_valid = 0, out_data = 0, out_ch = 0.
  - Accept on in_valid && in_ready: acc[ptr] <= (acc[ptr] + in_data) mod 2^LEN. Unsigned wrap; the carry is discarded.
  - ptr increments and wraps from CH-1 to 0.
  - When ptr == CH-1 on an accept: round_cnt increments.
  - If in addition round_cnt == DUMP-1: round_cnt <= 0, ptr <= 0, dump_idx <= 0, state <= DUMP.
- State DUMP:
  - in_ready = 0; in_valid is ignored and no samples are lost-counted.
  - out_valid = 1, out_ch = dump_idx, out_data = (acc[dump_idx] << SHIFT) mod 2^LEN.
  - On out_valid && out_ready: acc[dump_idx] <= 0 and dump_idx increments.
  - If dump_idx == CH-1: state <= ACC, and in_ready = 1 from the next cycle.
  - While out_ready is low, out_data and out_ch hold stable.
- Latency:
  - First out_valid is high the cycle after the final sample of the period is accepted.
  - With out_ready held high, a dump takes exactly CH cycles.
- clear high at a clock edge:
  - Same effect as reset, but synchronous; it aborts an in-progress dump.
  - No beat is transferred in that cycle, regardless of in_valid or out_ready.
- Simultaneous events:
  - Samples cannot be accepted during DUMP, so no accumulator is written by both paths.
  - clear overrides any accept or output transfer in the same cycle.
- Reset mid-operation: immediate return to the reset state; a partial period is discarded.

Optional Feature:
- Macro: ACC_DUMP_SCALER_SAT_EN.
- Defined:
  - Accumulation saturates at 2^LEN-1 instead of wrapping.
  - Scaling saturates: if any of the top SHIFT bits of acc are set, out_data = 2^LEN-1.
- Undefined: modular wrap in both accumulation and scaling, as described above.

Test Plan:
- LEN=8, CH=2, DUMP=2, SHIFT=1, out_ready=1; inputs 3,5,4,6 -> acc0=7, acc1=11; outputs (ch0,14) then (ch1,22) on consecutive cycles; in_ready=0 for 2 cycles, then 1.
- CH=1, DUMP=2, SHIFT=1; inputs 200,100:
  - without macro: acc=44, out_data=88.
  - with ACC_DUMP_SCALER_SAT_EN: acc=255, out_data=255.
- Backpressure: during DUMP hold out_ready=0 for 5 cycles while in_valid=1 with data 9 -> out_valid stays 1; out_data/out_ch unchanged; no accumulator changes; on release, normal dump.
- clear after 3 of 4 samples (CH=2, DUMP=2) -> next dump reflects only the 4 samples following clear; ptr restarts at ch0.
- rst_n low mid-dump (after ch0 output of CH=4) -> out_valid=0 immediately; after release in_ready=1; the next full period yields outputs from zeroed accumulators.
- Defaults (LEN=8, CH=4, DUMP=16, SHIFT=1); constant input 1 -> each channel acc=16, out_data=32 for ch0..3; the second period gives identical results, confirming the clear-on-dump.
